// File: rtl/vec_mem_seq.sv
// Four-lane vector load/store sequencer: walks lanes 0..3 in order, issuing one memory request per enabled lane.
// Optional macro VMEM_ALIGN_CHK_EN skips misaligned enabled lanes and raises a sticky misalign flag.
module vec_mem_seq #(
    parameter int VLEN  = 128,
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_store,
    input  logic [VLEN-1:0]  addr_vec,
    input  logic [3:0]       elem_en,
    input  logic [VLEN-1:0]  st_data,
    output logic [VLEN-1:0]  ld_data,
    output logic             busy,
    output logic             done,
    output logic             mem_req,
    output logic             mem_we,
    output logic [width-1:0] mem_addr,
    output logic [width-1:0] mem_wdata,
    input  logic [width-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ELEM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic              is_store_q, is_store_d;
    logic [VLEN-1:0]   addr_q, addr_d;
    logic [3:0]        en_q, en_d;
    logic [VLEN-1:0]   wdata_q, wdata_d;
    logic [VLEN-1:0]   ld_q, ld_d;

    logic              accept_s;
    logic              lane_en_s;
    logic              lane_bad_s;
    logic              lane_req_s;
    logic              step_s;
    logic [width-1:0]  lane_addr_s;
    logic [width-1:0]  lane_wdata_s;

    function automatic logic [width-1:0] lane_sel(input logic [VLEN-1:0] vec, input logic [1:0] idx);
        logic [width-1:0] r;
        case (idx)
            2'd0:    r = vec[width-1:0];
            2'd1:    r = vec[2*width-1:width];
            2'd2:    r = vec[3*width-1:2*width];
            2'd3:    r = vec[4*width-1:3*width];
            default: r = {width{1'b0}};
        endcase
        return r;
    endfunction

    // Current-lane decode shared by the FSM and the datapath.
    always_comb begin
        accept_s     = (state_q == S_IDLE) && start;
        lane_addr_s  = lane_sel(addr_q, idx_q);
        lane_wdata_s = lane_sel(wdata_q, idx_q);
        lane_en_s    = en_q[idx_q];
`ifdef VMEM_ALIGN_CHK_EN
        lane_bad_s   = (lane_addr_s[1:0] != 2'b00);
`else
        lane_bad_s   = 1'b0;
`endif
        lane_req_s   = (state_q == S_ELEM) && lane_en_s && !lane_bad_s;
        // A lane with no request retires in one cycle; a requested lane waits for its ack.
        step_s       = (state_q == S_ELEM) && (!lane_req_s || mem_ack);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ELEM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ELEM: begin
                if (step_s && (idx_q == 2'd3)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ELEM;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and memory interface drive.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        mem_req   = lane_req_s;
        mem_we    = lane_req_s && is_store_q;
        ld_data   = ld_q;
        if (lane_req_s) begin
            mem_addr = lane_addr_s;
        end else begin
            mem_addr = {width{1'b0}};
        end
        if (lane_req_s && is_store_q) begin
            mem_wdata = lane_wdata_s;
        end else begin
            mem_wdata = {width{1'b0}};
        end
    end

    // Datapath next-state: latch operands on accept, collect load lanes as they complete.
    always_comb begin
        idx_d      = idx_q;
        is_store_d = is_store_q;
        addr_d     = addr_q;
        en_d       = en_q;
        wdata_d    = wdata_q;
        ld_d       = ld_q;
        if (accept_s) begin
            idx_d      = 2'd0;
            is_store_d = is_store;
            addr_d     = addr_vec;
            en_d       = elem_en;
            wdata_d    = st_data;
            ld_d       = {VLEN{1'b0}};
        end else if (step_s) begin
            idx_d = idx_q + 2'd1;
            if (lane_req_s && !is_store_q) begin
                for (int i = 0; i < 4; i++) begin
                    if (idx_q == 2'(i)) begin
                        ld_d[i*width +: width] = mem_rdata;
                    end else begin
                        ld_d[i*width +: width] = ld_q[i*width +: width];
                    end
                end
            end else begin
                ld_d = ld_q;
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= 2'd0;
            is_store_q <= 1'b0;
            addr_q     <= {VLEN{1'b0}};
            en_q       <= 4'b0000;
            wdata_q    <= {VLEN{1'b0}};
            ld_q       <= {VLEN{1'b0}};
        end else begin
            idx_q      <= idx_d;
            is_store_q <= is_store_d;
            addr_q     <= addr_d;
            en_q       <= en_d;
            wdata_q    <= wdata_d;
            ld_q       <= ld_d;
        end
    end

`ifdef VMEM_ALIGN_CHK_EN
    logic misalign_q, misalign_d;

    // Sticky misalign flag, cleared only by an accepted start.
    always_comb begin
        if (accept_s) begin
            misalign_d = 1'b0;
        end else if (step_s && lane_en_s && lane_bad_s) begin
            misalign_d = 1'b1;
        end else begin
            misalign_d = misalign_q;
        end
    end

    // Misalign flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_vec_mem_seq.sv
// Randomized self-checking bench for vec_mem_seq with a transaction-level reference model and a
// memory responder with programmable ack delay; honours VMEM_ALIGN_CHK_EN like the design.
module tb_vec_mem_seq;
    localparam int VLEN = 128;
    localparam int W    = 32;
`ifdef VMEM_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            start;
    logic            is_store;
    logic [VLEN-1:0] addr_vec;
    logic [3:0]      elem_en;
    logic [VLEN-1:0] st_data;
    logic [VLEN-1:0] ld_data;
    logic            busy;
    logic            done;
    logic            mem_req;
    logic            mem_we;
    logic [W-1:0]    mem_addr;
    logic [W-1:0]    mem_wdata;
    logic [W-1:0]    mem_rdata;
    logic            mem_ack;
    logic            misalign;

    vec_mem_seq #(.VLEN(VLEN), .width(W)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .addr_vec(addr_vec),
        .elem_en(elem_en), .st_data(st_data), .ld_data(ld_data), .busy(busy), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          stab_err  = 0;
    logic [31:0] rkey = 32'h0;
    req_t        held;
    req_t        obs_q[$];

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a ^ rkey) + 32'd1;
    endfunction

    // Memory responder: acks after ack_delay wait cycles, random acks while idle, records accepted requests.
    always @(negedge clk) begin
        if (rst || !mem_req) begin
            wait_cnt  = 0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end else begin
            if (wait_cnt > 0 && held !== {mem_we, mem_addr, mem_wdata}) stab_err++;
            held      = {mem_we, mem_addr, mem_wdata};
            mem_rdata = mem_model(mem_addr);
            if (wait_cnt >= ack_delay) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                obs_q.push_back(held);
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    task automatic run_op(input string nm, input logic st, input logic [127:0] av, input logic [3:0] en,
                          input logic [127:0] sd, input int dly, input bit noise);
        req_t        exp_q[$];
        logic [127:0] exp_ld;
        logic        exp_mis;
        int          exp_cyc;
        int          cyc;
        logic [31:0] a;
        bit          bad;
        exp_ld  = '0;
        exp_mis = 1'b0;
        exp_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            a   = av[32*i +: 32];
            bad = ALIGN_CHK && (a[1:0] != 2'b00);
            if (en[i] && !bad) begin
                exp_q.push_back({st, a, st ? sd[32*i +: 32] : 32'h0});
                exp_cyc += 1 + dly;
                if (!st) exp_ld[32*i +: 32] = mem_model(a);
            end else begin
                exp_cyc += 1;
                if (en[i]) exp_mis = 1'b1;
            end
        end
        obs_q.delete();
        stab_err  = 0;
        ack_delay = dly;
        @(negedge clk);
        start = 1'b1; is_store = st; addr_vec = av; elem_en = en; st_data = sd;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start: got %b exp 1", nm, busy); end
        n_checks++;
        if (misalign !== 1'b0) begin n_fail++; $display("FAIL %s misalign_clear: got %b exp 0", nm, misalign); end
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (noise) begin
                start    = 1'($urandom_range(0, 1));
                is_store = 1'($urandom_range(0, 1));
                elem_en  = 4'($urandom);
                addr_vec = {$urandom, $urandom, $urandom, $urandom};
                st_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        n_checks++;
        if (cyc != exp_cyc) begin n_fail++; $display("FAIL %s done_latency: got %0d exp %0d", nm, cyc, exp_cyc); end
        n_checks++;
        if (ld_data !== exp_ld) begin n_fail++; $display("FAIL %s ld_data: got %h exp %h", nm, ld_data, exp_ld); end
        n_checks++;
        if (misalign !== exp_mis) begin n_fail++; $display("FAIL %s misalign: got %b exp %b", nm, misalign, exp_mis); end
        n_checks++;
        if (stab_err !== 0) begin n_fail++; $display("FAIL %s req_stable: got %0d changes exp 0", nm, stab_err); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s req_count: got %0d exp %0d", nm, obs_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL %s req%0d: got %h exp %h", nm, k, obs_q[k], exp_q[k]);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL %s done_one_cycle: got done=%b busy=%b exp 0 0", nm, done, busy); end
        n_checks++;
        if (ld_data !== exp_ld) begin n_fail++; $display("FAIL %s ld_hold: got %h exp %h", nm, ld_data, exp_ld); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; is_store = 1'b0; addr_vec = '0; elem_en = 4'b0; st_data = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, mem_req, mem_we, misalign} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b exp 00000", {busy, done, mem_req, mem_we, misalign});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, ld_data} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h/%h exp 0", mem_addr, mem_wdata, ld_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_basic();
        rkey = 32'h0;
        run_op("load_basic", 1'b0, {32'h10C, 32'h108, 32'h104, 32'h100}, 4'b1111, '0, 0, 1'b0);
        n_checks++;
        if (ld_data !== 128'h0000010D_00000109_00000105_00000101) begin
            n_fail++; $display("FAIL load_basic_const: got %h exp 0000010d000001090000010500000101", ld_data);
        end
    endtask

    task automatic test_store_sparse();
        run_op("store_sparse", 1'b1, {32'h40C, 32'h408, 32'h404, 32'h400}, 4'b0101,
               {32'hDD, 32'hCC, 32'hBB, 32'hAA}, 0, 1'b0);
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++; $display("FAIL store_two_reqs: got %0d exp 2", obs_q.size());
        end else begin
            n_checks++;
            if ({obs_q[0].addr, obs_q[0].wdata, obs_q[1].addr, obs_q[1].wdata} !== {32'h400, 32'hAA, 32'h408, 32'hCC}) begin
                n_fail++; $display("FAIL store_values: got %h %h %h %h exp 400 aa 408 cc",
                                   obs_q[0].addr, obs_q[0].wdata, obs_q[1].addr, obs_q[1].wdata);
            end
        end
        n_checks++;
        if (ld_data !== '0) begin n_fail++; $display("FAIL store_ld_zero: got %h exp 0", ld_data); end
    endtask

    task automatic test_load_wait();
        rkey = 32'h5A5A_0000;
        run_op("load_wait", 1'b0, {32'h3C, 32'h28, 32'h14, 32'h00}, 4'b1111, '0, 2, 1'b1);
    endtask

    task automatic test_reset_mid();
        int n;
        int done_seen;
        ack_delay = 4;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; elem_en = 4'b1111; st_data = '0;
        addr_vec = {32'h50C, 32'h508, 32'h504, 32'h500};
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(mem_req === 1'b1 && mem_addr === 32'h504) && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 50) begin n_fail++; $display("FAIL rstmid_lane1_timeout: got %0d cycles exp <50", n); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_req, busy, done, misalign} !== 4'b0) begin
            n_fail++; $display("FAIL rstmid_ctrl: got %b exp 0000", {mem_req, busy, done, misalign});
        end
        n_checks++;
        if ({ld_data, mem_addr} !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h %h exp 0", ld_data, mem_addr); end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        n_checks++;
        if (done_seen !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d exp 0", done_seen); end
    endtask

    task automatic test_align();
        int found;
        rkey = 32'h0;
        run_op("align", 1'b0, {32'h20C, 32'h202, 32'h204, 32'h200}, 4'b1111, '0, 0, 1'b0);
        found = 0;
        foreach (obs_q[k]) if (obs_q[k].addr === 32'h202) found++;
        n_checks++;
        if (found !== (ALIGN_CHK ? 0 : 1)) begin
            n_fail++; $display("FAIL align_req202: got %0d exp %0d", found, ALIGN_CHK ? 0 : 1);
        end
        run_op("align_next", 1'b0, {32'h21C, 32'h218, 32'h214, 32'h210}, 4'b1111, '0, 1, 1'b0);
    endtask

    task automatic test_random();
        logic [127:0] av;
        logic [31:0]  a;
        for (int t = 0; t < 25; t++) begin
            rkey = $urandom;
            for (int i = 0; i < 4; i++) begin
                a = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
                av[32*i +: 32] = a;
            end
            run_op("random", 1'($urandom_range(0, 1)), av, 4'($urandom), {$urandom, $urandom, $urandom, $urandom},
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_sparse();
        test_load_wait();
        test_reset_mid();
        test_align();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_mem_seq.md
VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

Interface
REQ-001 SHALL have parameter VLEN, default 128, vector register width in bits.
REQ-002 SHALL have parameter width, default 32, element and memory word width; VLEN = 4*width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to run a 4-element vector memory op; sampled only in IDLE.
REQ-006 SHALL have port is_store  input  1  1 = store, 0 = load; latched on accepted start.
REQ-007 SHALL have port addr_vec  input  VLEN  element addresses, lane i at [32i+31:32i] (datapath ALU outputs 3..0); latched on accepted start.
REQ-008 SHALL have port elem_en  input  4  per-lane enable (datapath vm3..vm0); latched on accepted start.
REQ-009 SHALL have port st_data  input  VLEN  store data (datapath vs3_out); latched on accepted start.
REQ-010 SHALL have port ld_data  output  VLEN  assembled load result, feeds datapath XDMEM.
REQ-011 SHALL have port busy  output  1  high in any non-IDLE state.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port mem_req / mem_we  output  1 / 1  memory request and write-enable.
REQ-014 SHALL have port mem_addr / mem_wdata  output  32 / 32  memory address and write data.
REQ-015 SHALL have port mem_rdata / mem_ack  input  32 / 1  read data and acknowledge, sampled on clk edge while mem_req high.
REQ-016 SHALL have port misalign  output  1  sticky alignment error (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, ELEM, DONE, with 2-bit lane index idx.
REQ-018 IDLE: start=1 SHALL latch is_store, addr_vec, elem_en, st_data, clear ld_data and misalign, set idx=0, go to ELEM.
REQ-019 ELEM with elem_en[idx]=0 SHALL keep mem_req low and advance idx in one cycle; ld_data lane idx stays 0.
REQ-020 ELEM with elem_en[idx]=1 SHALL drive mem_req=1, mem_we=is_store, mem_addr=lane idx address, mem_wdata=lane idx store data (0 on loads), all stable until mem_ack.
REQ-021 On the edge where mem_req=1 and mem_ack=1, SHALL capture mem_rdata into ld_data lane idx (loads only) and advance idx; mem_ack=1 in the same cycle as mem_req is legal (1 cycle per element).
REQ-022 After lane 3 completes, SHALL go to DONE; DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-023 Lanes SHALL be processed strictly in order 0,1,2,3; at most one outstanding request.
REQ-024 start while busy=1 SHALL be ignored; mem_ack while mem_req=0 SHALL be ignored.
REQ-025 Latency: start accepted at edge T, all lanes enabled, zero-wait ack -> done high in cycle T+5; each ack wait cycle adds one cycle.
REQ-026 ld_data SHALL hold its value from DONE until the next accepted start; on stores, ld_data stays all-zero.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, idx=0, busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ld_data=0, misalign=0, including mid-operation; no done is produced for an aborted op.

Configuration
REQ-028 Macro VMEM_ALIGN_CHK_EN defined: an enabled lane with address[1:0]!=0 SHALL NOT issue mem_req, SHALL set misalign=1 (sticky until next accepted start), SHALL skip in one cycle like a disabled lane.
REQ-029 Macro VMEM_ALIGN_CHK_EN undefined: addresses SHALL pass unchecked and misalign SHALL be tied to 0.

Verification
REQ-030 Load, elem_en=4'b1111, addrs 0x100/0x104/0x108/0x10C, zero-wait ack, rdata=addr+1 -> done at T+5, ld_data=0x0000010D_00000109_00000105_00000101.
REQ-031 Store, elem_en=4'b0101, st_data lanes 0xDD/0xCC/0xBB/0xAA -> exactly two requests: (addr lane0, 0xAA, we=1) then (addr lane2, 0xCC, we=1); done at T+5.
REQ-032 Load, all lanes enabled, mem_ack delayed 2 cycles per lane -> mem_addr stable during wait, done at T+13, start pulses during busy ignored.
REQ-033 Load in progress, rst asserted while waiting on lane 1 -> mem_req low same cycle, busy=0, ld_data=0, no done pulse.
REQ-034 With VMEM_ALIGN_CHK_EN, lane 2 addr 0x202 -> lane 2 not requested, misalign=1 after DONE, cleared on next start; without macro the same stimulus issues 0x202 and misalign stays 0.
